// File: rtl/restoring_div_controller.sv
// restoring_div_controller: sequencing FSM for a shift/subtract restoring divider.
// Ports:
//   clk, rst (async, active-low)
//   start            level handshake (high, then low) accepted from IDLE/ARM
//   borrow, m_zero   datapath flags (R < M, M == 0)
//   r_reset, q_load, m_load, rq_shift, r_load, q_set   datapath strobes
//   busy, done, div_zero                               status
module restoring_div_controller #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic borrow,
    input  logic m_zero,
    output logic r_reset,
    output logic q_load,
    output logic m_load,
    output logic rq_shift,
    output logic r_load,
    output logic q_set,
    output logic busy,
    output logic done,
    output logic div_zero
);
    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, ARM, LOAD, ZCHK, SHIFT, TEST} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_zero_q, div_zero_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_zero_d = div_zero_q;
        r_reset    = 1'b0;
        q_load     = 1'b0;
        m_load     = 1'b0;
        rq_shift   = 1'b0;
        r_load     = 1'b0;
        q_set      = 1'b0;
        case (state_q)
            IDLE:  state_d = start ? ARM : IDLE;
            ARM:   state_d = start ? ARM : LOAD;
            LOAD: begin
                r_reset    = 1'b1;
                q_load     = 1'b1;
                m_load     = 1'b1;
                cnt_d      = '0;
                div_zero_d = 1'b0;
                state_d    = ZCHK;
            end
            ZCHK: begin
                div_zero_d = m_zero;
                state_d    = m_zero ? IDLE : SHIFT;
            end
            SHIFT: begin
                rq_shift = 1'b1;
                state_d  = TEST;
            end
            TEST: begin
                // restore is implicit: R is only overwritten when the subtract did not borrow
                r_load  = !borrow;
                q_set   = !borrow;
                // saturate on the last iteration so the counter never wraps
                cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? IDLE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = !(state_q == IDLE || state_q == ARM);
    assign done     = (state_q == IDLE);
    assign div_zero = div_zero_q;
endmodule

// File: tb/tb_restoring_div_controller.sv
// tb_restoring_div_controller: directed self-checking bench with behavioural R/Q/M datapaths.
// Ports: none (top-level bench driving a WIDTH=8 and a WIDTH=4 controller).
module tb_restoring_div_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, sel;
    logic [7:0] dividend, divisor;
    int         checks = 0;
    int         errors = 0;

    logic b8, z8, rr8, ql8, ml8, sh8, rl8, qs8, bu8, dn8, dz8;
    logic b4, z4, rr4, ql4, ml4, sh4, rl4, qs4, bu4, dn4, dz4;
    logic [8:0] r8;
    logic [7:0] q8, m8;
    logic [4:0] r4;
    logic [3:0] q4, m4;

    restoring_div_controller #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start && !sel), .borrow(b8), .m_zero(z8),
        .r_reset(rr8), .q_load(ql8), .m_load(ml8), .rq_shift(sh8), .r_load(rl8),
        .q_set(qs8), .busy(bu8), .done(dn8), .div_zero(dz8)
    );

    restoring_div_controller #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start && sel), .borrow(b4), .m_zero(z4),
        .r_reset(rr4), .q_load(ql4), .m_load(ml4), .rq_shift(sh4), .r_load(rl4),
        .q_set(qs4), .busy(bu4), .done(dn4), .div_zero(dz4)
    );

    always @(posedge clk) begin
        if (rr8) r8 <= '0;
        if (ql8) q8 <= dividend;
        if (ml8) m8 <= divisor;
        if (sh8) {r8, q8} <= {r8[7:0], q8, 1'b0};
        if (rl8) r8 <= r8 - {1'b0, m8};
        if (qs8) q8[0] <= 1'b1;
    end

    always @(posedge clk) begin
        if (rr4) r4 <= '0;
        if (ql4) q4 <= dividend[3:0];
        if (ml4) m4 <= divisor[3:0];
        if (sh4) {r4, q4} <= {r4[3:0], q4, 1'b0};
        if (rl4) r4 <= r4 - {1'b0, m4};
        if (qs4) q4[0] <= 1'b1;
    end

    assign b8 = r8 < {1'b0, m8};
    assign z8 = (m8 == 8'd0);
    assign b4 = r4 < {1'b0, m4};
    assign z4 = (m4 == 4'd0);

    logic       s_rr, s_sh, s_qs, s_rl, s_busy, s_done, s_dz;
    logic [7:0] res_q, res_r;
    assign s_rr   = sel ? rr4 : rr8;
    assign s_sh   = sel ? sh4 : sh8;
    assign s_qs   = sel ? qs4 : qs8;
    assign s_rl   = sel ? rl4 : rl8;
    assign s_busy = sel ? bu4 : bu8;
    assign s_done = sel ? dn4 : dn8;
    assign s_dz   = sel ? dz4 : dz8;
    assign res_q  = sel ? {4'd0, q4} : q8;
    assign res_r  = sel ? {4'd0, r4[3:0]} : r8[7:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // lat = cycles from the LOAD cycle until done is first seen
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold, input logic tog,
                         output int lat, output int sh, output int qs, output int rl);
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("arm_busy", s_busy, 0);
            check("arm_done", s_done, 0);
        end
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_rr && n < 8);
        check("load_seen", s_rr, 1);
        lat = 0; sh = 0; qs = 0; rl = 0;
        do begin
            @(negedge clk);
            lat++;
            sh += int'(s_sh);
            qs += int'(s_qs);
            rl += int'(s_rl);
            if (lat == 1) check("dz_clr", s_dz, 0);
            if (tog && !s_done) start = lat[0];
        end while (!s_done && lat < 60);
        start = 1'b0;
    endtask

    int lat, sh, qs, rl, n;

    initial begin
        rst = 1'b0; start = 1'b0; sel = 1'b0; dividend = '0; divisor = '0;
        #1;
        check("rst_done", dn8, 1);
        check("rst_busy", bu8, 0);
        check("rst_dz", dz8, 0);
        check("rst_strobes", {rr8, ql8, ml8, sh8, rl8, qs8}, 0);
        check("rst_done4", dn4, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        do_op(8'd13, 8'd4, 3, 1'b0, lat, sh, qs, rl);
        check("13_4_lat", lat, 18);
        check("13_4_shifts", sh, 8);
        check("13_4_qset", qs, 2);
        check("13_4_q", res_q, 3);
        check("13_4_r", res_r, 1);

        do_op(8'd255, 8'd1, 1, 1'b0, lat, sh, qs, rl);
        check("255_1_q", res_q, 255);
        check("255_1_r", res_r, 0);
        check("255_1_rload", rl, 8);

        do_op(8'd7, 8'd0, 2, 1'b0, lat, sh, qs, rl);
        check("7_0_lat", lat, 2);
        check("7_0_dz", s_dz, 1);
        check("7_0_done", s_done, 1);
        check("7_0_shifts", sh, 0);
        @(negedge clk);
        check("7_0_dz_hold", s_dz, 1);

        do_op(8'd9, 8'd3, 2, 1'b0, lat, sh, qs, rl);
        check("9_3_q", res_q, 3);
        check("9_3_r", res_r, 0);
        check("9_3_dz", s_dz, 0);

        @(negedge clk);
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_rr && n < 8);
        check("rst_op_load", s_rr, 1);
        repeat (11) @(negedge clk);
        check("mid_busy", s_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_strobes", {rr8, ql8, ml8, sh8, rl8, qs8}, 0);
        check("mid_rst_busy", bu8, 0);
        check("mid_rst_done", dn8, 1);
        @(negedge clk);
        rst = 1'b1;

        do_op(8'd200, 8'd7, 2, 1'b0, lat, sh, qs, rl);
        check("200_7_lat", lat, 18);
        check("200_7_q", res_q, 28);
        check("200_7_r", res_r, 4);

        do_op(8'd100, 8'd9, 20, 1'b1, lat, sh, qs, rl);
        check("tog_lat", lat, 18);
        check("tog_shifts", sh, 8);
        check("tog_q", res_q, 11);
        check("tog_r", res_r, 1);
        repeat (3) @(negedge clk);
        check("tog_idle", s_done, 1);

        sel = 1'b1;
        do_op(8'd15, 8'd2, 2, 1'b0, lat, sh, qs, rl);
        check("w4_lat", lat, 10);
        check("w4_shifts", sh, 4);
        check("w4_q", res_q, 7);
        check("w4_r", res_r, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
